// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
//   op_e        : operation select (add / subtract)
//   limb_width  : bits resolved per pipeline stage, ceil((size+1)/stages)
//   sat_max/min : SIZE-bit signed range limits, returned as 64-bit two's complement
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned limb_width(int unsigned size, int unsigned stages);
    return (size + stages) / stages;
  endfunction

  function automatic logic [63:0] sat_max(int unsigned size);
    return (64'd1 << (size - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(int unsigned size);
    return ~sat_max(size);
  endfunction

endpackage

// File: rtl/addsub_limb_stage.sv
// One registered limb of the ripple-carry pipeline.
// Adds limb LimbIdx of the (pre-inverted) operands with the incoming carry, writes it into
// the partial result, and registers carry, operands, partial result, tag and valid.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i                 global advance enable (0 = hold every register)
//   valid_i/valid_o      stage occupancy
//   carry_i/carry_o      carry into / out of this limb
//   a_i, b_i / a_o, b_o  padded operands, skewed forward unchanged
//   sum_i / sum_o        partial result; lower limbs already resolved
//   tag_i / tag_o        opaque user tag
module addsub_limb_stage #(
  parameter int unsigned Width   = 10,
  parameter int unsigned LimbW   = 5,
  parameter int unsigned LimbIdx = 0,
  parameter int unsigned TagW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] sum_i,
  input  logic [TagW-1:0]  tag_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic [Width-1:0] a_o,
  output logic [Width-1:0] b_o,
  output logic [Width-1:0] sum_o,
  output logic [TagW-1:0]  tag_o
);

  localparam int unsigned Lo = LimbIdx * LimbW;

  logic             valid_q, valid_d;
  logic             carry_q, carry_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [Width-1:0] sum_q, sum_d;
  logic [TagW-1:0]  tag_q, tag_d;
  logic [LimbW:0]   limb_sum;

  // This limb of sum_i has not been resolved yet and is always overwritten here.
  logic unused_limb;
  assign unused_limb = ^sum_i[Lo +: LimbW];

  always_comb begin
    limb_sum = {1'b0, a_i[Lo +: LimbW]} + {1'b0, b_i[Lo +: LimbW]} + {{LimbW{1'b0}}, carry_i};
    valid_d  = valid_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    tag_d    = tag_q;
    if (en_i) begin
      valid_d              = valid_i;
      carry_d              = limb_sum[LimbW];
      a_d                  = a_i;
      b_d                  = b_i;
      sum_d                = sum_i;
      sum_d[Lo +: LimbW]   = limb_sum[LimbW-1:0];
      tag_d                = tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Signed add/subtract unit, ripple-carry pipelined over STAGES limbs with valid/ready flow.
// Result is SIZE+1 bits (exact); overflow flags a result outside the SIZE-bit signed range.
// Optional: define ADDSUB_SATURATE_EN to clamp overflowing results to the SIZE-bit range.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready = !out_valid | out_ready
//   op_sub                0: a+b, 1: a-b
//   a, b, in_tag          signed operands and pass-through tag
//   out_valid/out_ready   output handshake
//   result, overflow      sign-extended result and SIZE-bit overflow flag
//   out_tag               tag of the operation in result
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE:0]    result,
  output logic             overflow,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned ResW  = SIZE + 1;
  localparam int unsigned LimbW = limb_width(SIZE, STAGES);
  // Operands are sign-extended past ResW so every limb has full width; the low ResW bits
  // of the padded sum equal the exact result.
  localparam int unsigned PadW  = LimbW * STAGES;

  op_e             op;
  logic            advance;
  logic [PadW-1:0] b_ext;

  logic             valid_c [STAGES+1];
  logic             carry_c [STAGES+1];
  logic [PadW-1:0]  a_c     [STAGES+1];
  logic [PadW-1:0]  b_c     [STAGES+1];
  logic [PadW-1:0]  sum_c   [STAGES+1];
  logic [TAG_W-1:0] tag_c   [STAGES+1];

  logic [ResW-1:0] sum_fin;

  // Stall is global: nothing moves while the output is held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign op         = op_e'(op_sub);
  assign b_ext      = {{(PadW - SIZE){b[SIZE-1]}}, b};
  assign valid_c[0] = in_valid;
  assign carry_c[0] = (op == OP_SUB);
  assign a_c[0]     = {{(PadW - SIZE){a[SIZE-1]}}, a};
  assign b_c[0]     = (op == OP_SUB) ? ~b_ext : b_ext;
  assign sum_c[0]   = '0;
  assign tag_c[0]   = in_tag;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_limb_stage #(
      .Width  (PadW),
      .LimbW  (LimbW),
      .LimbIdx(k),
      .TagW   (TAG_W)
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (advance),
      .valid_i(valid_c[k]),
      .carry_i(carry_c[k]),
      .a_i    (a_c[k]),
      .b_i    (b_c[k]),
      .sum_i  (sum_c[k]),
      .tag_i  (tag_c[k]),
      .valid_o(valid_c[k+1]),
      .carry_o(carry_c[k+1]),
      .a_o    (a_c[k+1]),
      .b_o    (b_c[k+1]),
      .sum_o  (sum_c[k+1]),
      .tag_o  (tag_c[k+1])
    );
  end

  // Final carry and skewed operands have no consumer past the last stage.
  logic unused_tail;
  assign unused_tail = ^{carry_c[STAGES], a_c[STAGES], b_c[STAGES]};

  if (PadW > ResW) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^sum_c[STAGES][PadW-1:ResW];
  end

`ifdef ADDSUB_SATURATE_EN
  localparam logic [63:0] SatMax = sat_max(SIZE);
  localparam logic [63:0] SatMin = sat_min(SIZE);
`endif

  always_comb begin
    sum_fin  = sum_c[STAGES][ResW-1:0];
    overflow = sum_fin[SIZE] ^ sum_fin[SIZE-1];
`ifdef ADDSUB_SATURATE_EN
    if (overflow) begin
      result = sum_fin[SIZE] ? SatMin[ResW-1:0] : SatMax[ResW-1:0];
    end else begin
      result = sum_fin;
    end
`else
    result = sum_fin;
`endif
  end

  assign out_valid = valid_c[STAGES];
  assign out_tag   = tag_c[STAGES];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed cases on an 8-bit/2-stage unit plus
// scoreboarded random traffic on several SIZE/STAGES configurations.
module tb_pipelined_addsub;

  localparam int unsigned STAGES = 2;

  logic       clk;
  logic       rst_n;
  logic       rst_n_r;
  logic       in_valid;
  logic       in_ready;
  logic       op_sub;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] result;
  logic       overflow;
  logic [3:0] out_tag;

  int n_checks;
  int n_fail;
  int n_out;
  int n_done;
  int n0;
  int stall_t;

  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;
  logic [8:0]  hold_res;
  logic [3:0]  hold_tag;

  pipelined_addsub #(
    .SIZE  (8),
    .STAGES(STAGES),
    .TAG_W (4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: packs {tag, overflow, result} in the same layout as the DUT outputs.
  function automatic logic [63:0] exp_word(input int unsigned size, input logic sub,
                                           input logic [31:0] av_in, input logic [31:0] bv_in,
                                           input logic [3:0] tag);
    longint hi, lo, av, bv, r, span;
    logic   ovf;
    logic [63:0] rb;
    span = longint'(1) << size;
    hi   = (longint'(1) << (size - 1)) - 1;
    lo   = -hi - 1;
    av   = longint'(av_in) & (span - 1);
    bv   = longint'(bv_in) & (span - 1);
    if (av > hi) av = av - span;
    if (bv > hi) bv = bv - span;
    r    = sub ? (av - bv) : (av + bv);
    ovf  = (r > hi) || (r < lo);
`ifdef ADDSUB_SATURATE_EN
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`endif
    rb = 64'(r) & ((64'd1 << (size + 1)) - 64'd1);
    return (64'(tag) << (size + 2)) | (64'(ovf) << (size + 1)) | rb;
  endfunction

  function automatic int unsigned cfg_size(input int unsigned i);
    return (i < 3) ? 8 : 13;
  endfunction

  function automatic int unsigned cfg_stages(input int unsigned i);
    return (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 3 : 9);
  endfunction

  // Scoreboard for the main DUT: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 64'(1), 64'(0));
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_result", 64'({out_tag, overflow, result}), sb_exp);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_word(8, op_sub, 32'(a), 32'(b), in_tag));
    end
  end

  // Caller is at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic sub, input logic [7:0] av, input logic [7:0] bv,
                      input logic [3:0] tg);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    op_sub   = sub;
    a        = av;
    b        = bv;
    in_tag   = tg;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_main(input string tag);
    for (int i = 0; i < 60 && (sb_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 64'(sb_q.size()), 64'(0));
  endtask

  // Random traffic on additional configurations, each with its own scoreboard.
  for (genvar g = 0; g < 6; g++) begin : g_rnd
    localparam int unsigned SZ = cfg_size(g);
    localparam int unsigned ST = cfg_stages(g);

    logic          iv, ir, op, ov, orr, ovf;
    logic [SZ-1:0] ar, br;
    logic [3:0]    ti, to;
    logic [SZ:0]   res;
    logic [63:0]   q[$];
    logic [63:0]   ew;

    pipelined_addsub #(
      .SIZE  (SZ),
      .STAGES(ST),
      .TAG_W (4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n_r),
      .in_valid (iv),
      .in_ready (ir),
      .op_sub   (op),
      .a        (ar),
      .b        (br),
      .in_tag   (ti),
      .out_valid(ov),
      .out_ready(orr),
      .result   (res),
      .overflow (ovf),
      .out_tag  (to)
    );

    always @(negedge clk) begin
      if (rst_n_r) begin
        if (ov && orr) begin
          if (q.size() == 0) begin
            check($sformatf("rnd%0d_unexpected", g), 64'(1), 64'(0));
          end else begin
            ew = q.pop_front();
            check($sformatf("rnd%0d_result", g), 64'({to, ovf, res}), ew);
          end
        end
        if (iv && ir) q.push_back(exp_word(SZ, op, 32'(ar), 32'(br), ti));
      end
    end

    initial begin
      iv  = 1'b0;
      orr = 1'b0;
      op  = 1'b0;
      ar  = '0;
      br  = '0;
      ti  = '0;
      wait (rst_n_r);
      @(posedge clk);
      #1;
      for (int i = 0; i < 400; i++) begin
        iv  = ($urandom % 3) != 0;
        op  = 1'($urandom);
        ar  = ($urandom % 5 == 0) ? {1'b1, {(SZ - 1){1'b0}}} : SZ'($urandom);
        br  = ($urandom % 5 == 0) ? {1'b1, {(SZ - 1){1'b0}}} : SZ'($urandom);
        ti  = 4'($urandom);
        orr = ($urandom % 4) != 0;
        @(posedge clk);
        #1;
      end
      iv  = 1'b0;
      orr = 1'b1;
      for (int i = 0; i < 40 && (q.size() != 0 || ov); i++) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("rnd%0d_drain", g), 64'(q.size()), 64'(0));
      n_done++;
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_out     = 0;
    n_done    = 0;
    rst_n     = 1'b0;
    rst_n_r   = 1'b0;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    check("reset_out_tag", 64'(out_tag), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));

    @(negedge clk);
    rst_n   = 1'b1;
    rst_n_r = 1'b1;
    @(posedge clk);
    #1;

    // Latency: 5 - 7 with tag A.
    send(1'b1, 8'd5, 8'd7, 4'hA);
    for (int k = 1; k <= STAGES; k++) begin
      @(negedge clk);
      check($sformatf("latency_c%0d", k), 64'(out_valid), 64'(k == STAGES));
    end
    check("sub5_7_result", 64'(result), 64'(9'h1FE));
    check("sub5_7_overflow", 64'(overflow), 64'(0));
    check("sub5_7_tag", 64'(out_tag), 64'(4'hA));
    @(posedge clk);
    #1;

    // Positive overflow: 127 - (-128).
    send(1'b1, 8'h7F, 8'h80, 4'h1);
    repeat (STAGES) @(negedge clk);
    check("sub7f_80_valid", 64'(out_valid), 64'(1));
`ifdef ADDSUB_SATURATE_EN
    check("sub7f_80_result", 64'(result), 64'(9'h07F));
`else
    check("sub7f_80_result", 64'(result), 64'(9'h0FF));
`endif
    check("sub7f_80_overflow", 64'(overflow), 64'(1));
    @(posedge clk);
    #1;

    // Negative overflow: -128 + -128.
    send(1'b0, 8'h80, 8'h80, 4'h2);
    repeat (STAGES) @(negedge clk);
`ifdef ADDSUB_SATURATE_EN
    check("add80_80_result", 64'(result), 64'(9'h180));
`else
    check("add80_80_result", 64'(result), 64'(9'h100));
`endif
    check("add80_80_overflow", 64'(overflow), 64'(1));
    @(posedge clk);
    #1;
    drain_main("directed_drain");

    // Stall: 4 back-to-back ops with the consumer held off for 3 cycles.
    n0        = n_out;
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 8'h01, 8'h02, 4'h1);
        send(1'b1, 8'h10, 8'h03, 4'h2);
        send(1'b0, 8'h7F, 8'h01, 4'h3);
        send(1'b1, 8'h80, 8'h01, 4'h4);
      end
      begin
        stall_t = 0;
        @(negedge clk);
        while (!out_valid && stall_t < 20) begin
          @(negedge clk);
          stall_t++;
        end
        check("stall_out_valid", 64'(out_valid), 64'(1));
        hold_res = result;
        hold_tag = out_tag;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'(0));
          check("stall_result_stable", 64'(result), 64'(hold_res));
          check("stall_tag_stable", 64'(out_tag), 64'(hold_tag));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain_main("stall_drain");
    check("stall_delivered", 64'(n_out - n0), 64'(4));

    // Reset with two operations in flight.
    send(1'b0, 8'h11, 8'h22, 4'h3);
    send(1'b1, 8'h40, 8'h01, 4'h4);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (STAGES + 1) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    send(1'b0, 8'h10, 8'h20, 4'h5);
    repeat (STAGES) @(negedge clk);
    check("postrst_valid", 64'(out_valid), 64'(1));
    check("postrst_result", 64'(result), 64'(9'h030));
    check("postrst_tag", 64'(out_tag), 64'(4'h5));
    @(posedge clk);
    #1;
    drain_main("postrst_drain");

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      op_sub    = 1'($urandom);
      a         = ($urandom % 4 == 0) ? 8'h80 : 8'($urandom);
      b         = ($urandom % 4 == 0) ? 8'h80 : 8'($urandom);
      in_tag    = 4'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain_main("random_drain");

    for (int i = 0; i < 3000 && n_done < 6; i++) @(posedge clk);
    check("rnd_configs_done", 64'(n_done), 64'(6));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
